apb_initiator: RTL and testbench
================================

APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum ACCESS-phase cycles before abort; 0 disables the timeout.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1 / req_ready  out  1  request handshake.
REQ-006 req_addr  in  32 / req_write  in  1 / req_wdata  in  32 / req_wstrb  in  4  request payload.
REQ-007 resp_valid  out  1 / resp_ready  in  1  response handshake.
REQ-008 resp_rdata  out  32 / resp_err  out  1  response payload.
REQ-009 out_paddr  out  32, out_psel  out  1, out_penable  out  1, out_pprot  out  3, out_pwrite  out  1, out_pwdata  out  32, out_pstrb  out  4: APB4 requester signals.
REQ-010 out_pready  in  1, out_prdata  in  32, out_pslverr  in  1: APB4 completer signals.

Function
REQ-011 States: IDLE, SETUP, ACCESS, RESP; at most one transaction outstanding.
REQ-012 IDLE: req_ready=1; all other states: req_ready=0.
REQ-013 A handshake (req_valid&&req_ready) in IDLE latches addr/write/wdata/wstrb, then transitions to SETUP.
REQ-014 SETUP lasts exactly one cycle with psel=1, penable=0, then transitions to ACCESS.
REQ-015 ACCESS: psel=1, penable=1, held until pready=1 or timeout.
REQ-016 paddr, pwrite, pwdata and pstrb are driven from latched registers and remain stable from SETUP through the end of ACCESS.
REQ-017 pstrb=4'b0000 for reads; pprot=3'b000 always.
REQ-018 On pready=1 in ACCESS: capture prdata (reads) or 0 (writes) into resp_rdata, capture pslverr into resp_err, transition to RESP.
REQ-019 A timeout counter clears on SETUP entry and increments each ACCESS cycle with pready=0.
REQ-020 When the timeout counter reaches TIMEOUT and pready=0: resp_rdata=0, resp_err=1, transition to RESP; psel and penable deassert in RESP.
REQ-021 pready sampled in the same cycle as the timeout boundary takes priority, giving a normal completion.
REQ-022 RESP: resp_valid=1, psel=0, penable=0; resp_rdata and resp_err are held stable until resp_ready=1, then transition to IDLE.
REQ-023 Minimum latency from request handshake to resp_valid is 3 cycles (SETUP, ACCESS, RESP), plus one cycle per wait state.
REQ-024 A new request can be accepted no earlier than the cycle after the response handshake.
REQ-025 In IDLE, paddr/pwdata/pwrite hold their last values and psel/penable are 0.

Reset
REQ-026 While reset=0: state=IDLE, psel=0, penable=0, resp_valid=0, req_ready=0, resp_err=0, and all data/address registers=0.
REQ-027 req_ready becomes 1 on the first clock edge after reset deasserts.
REQ-028 Reset asserted mid-transaction drops psel/penable immediately (asynchronously), discards the transaction, and produces no response.

Structure
REQ-029 Package apb_pkg SHALL hold the state enum, APB_PROT_DEFAULT (3'b000), and the address/data width constants (32).
REQ-030 The block is implemented as a single module with no sub-modules; the timeout counter is inline, $clog2(TIMEOUT+1) bits wide.

Verification
REQ-031 Write 0x1000_0008, data 0x1234_5678, strb 0xF, zero wait states -> psel@+1, penable@+2, resp_valid@+3, resp_err=0.
REQ-032 Read 0x1000_0004 with 3 wait states, prdata=0xDEADBEEF -> resp_rdata=0xDEADBEEF, pstrb=0 throughout, resp_valid@+6.
REQ-033 Write with pslverr=1 on the pready cycle -> resp_err=1, resp_rdata=0.
REQ-034 TIMEOUT=16, completer never asserts pready -> resp_valid with resp_err=1 after 16 ACCESS cycles; psel=0 in RESP.
REQ-035 resp_ready held low for 5 cycles -> resp_valid and data held stable, req_ready=0 throughout, then IDLE; a back-to-back second request is accepted the cycle after.
REQ-036 Reset asserted during ACCESS -> psel=0 immediately, no resp_valid, req_ready=1 on the first edge after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB4 initiator: widths, protection default, FSM states.
package apb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  // Normal, secure, data access.
  localparam logic [2:0] APB_PROT_DEFAULT = 3'b000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_initiator.sv
// Single-outstanding APB4 requester: accepts one request, runs SETUP/ACCESS on the bus,
// and returns read data / error through a valid-ready response channel.
module apb_initiator
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,

  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,

  output logic [ADDR_W-1:0] out_paddr,
  output logic              out_psel,
  output logic              out_penable,
  output logic [2:0]        out_pprot,
  output logic              out_pwrite,
  output logic [DATA_W-1:0] out_pwdata,
  output logic [STRB_W-1:0] out_pstrb,

  input  logic              out_pready,
  input  logic [DATA_W-1:0] out_prdata,
  input  logic              out_pslverr
);

  // A zero TIMEOUT still needs a legal (unused) counter width.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic TO_EN = (TIMEOUT > 0);

  apb_state_e state, state_nxt;

  logic              rdy_en;
  logic              req_hs;
  logic              timeout_hit;
  logic [CNT_W-1:0]  cnt;

  logic [ADDR_W-1:0] addr_p0;
  logic              write_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [STRB_W-1:0] strb_p0;

  logic [DATA_W-1:0] rdata_p1;
  logic              err_p1;

  assign req_hs      = req_valid && req_ready;
  // Aborts on the cycle the counter would reach TIMEOUT; a same-cycle pready wins.
  assign timeout_hit = TO_EN && (state == ACCESS) && !out_pready && (cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    out_psel    = 1'b0;
    out_penable = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rdy_en;
        if (req_valid && rdy_en) state_nxt = SETUP;
      end
      SETUP: begin
        out_psel  = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        out_psel    = 1'b1;
        out_penable = 1'b1;
        if (out_pready || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture: bus payload held from SETUP through ACCESS and while idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_p0  <= '0;
      write_p0 <= 1'b0;
      wdata_p0 <= '0;
      strb_p0  <= '0;
    end else if (req_hs) begin
      addr_p0  <= req_addr;
      write_p0 <= req_write;
      wdata_p0 <= req_wdata;
      strb_p0  <= req_write ? req_wstrb : '0;
    end
  end

  // Completion capture and wait-state counting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
      cnt      <= '0;
    end else begin
      if (req_hs) begin
        cnt <= '0;
      end else if (state == ACCESS) begin
        if (out_pready) begin
          rdata_p1 <= write_p0 ? '0 : out_prdata;
          err_p1   <= out_pslverr;
        end else if (timeout_hit) begin
          rdata_p1 <= '0;
          err_p1   <= 1'b1;
        end else if (TO_EN) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign out_paddr  = addr_p0;
  assign out_pwrite = write_p0;
  assign out_pwdata = wdata_p0;
  assign out_pstrb  = strb_p0;
  assign out_pprot  = APB_PROT_DEFAULT;
  assign resp_rdata = rdata_p1;
  assign resp_err   = err_p1;

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator: handshake timing, wait states, errors, timeout, reset abort.
module tb_apb_initiator;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] out_paddr;
  logic        out_psel;
  logic        out_penable;
  logic [2:0]  out_pprot;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready = 1'b0;
  logic [31:0] out_prdata = '0;
  logic        out_pslverr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  apb_initiator #(.TIMEOUT(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .out_paddr   (out_paddr),
    .out_psel    (out_psel),
    .out_penable (out_penable),
    .out_pprot   (out_pprot),
    .out_pwrite  (out_pwrite),
    .out_pwdata  (out_pwdata),
    .out_pstrb   (out_pstrb),
    .out_pready  (out_pready),
    .out_prdata  (out_prdata),
    .out_pslverr (out_pslverr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents a request, checks it is accepted, and returns one cycle later (SETUP, +1).
  task automatic send_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    req_wstrb = s;
    check("req_ready_at_hs", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;

    // Reset state
    tick();
    tick();
    check("rst_psel",      32'(out_psel),    32'd0);
    check("rst_penable",   32'(out_penable), 32'd0);
    check("rst_req_ready", 32'(req_ready),   32'd0);
    check("rst_resp_vld",  32'(resp_valid),  32'd0);
    check("rst_resp_err",  32'(resp_err),    32'd0);
    check("rst_paddr",     out_paddr,        32'd0);
    check("rst_pwdata",    out_pwdata,       32'd0);
    check("rst_rdata",     resp_rdata,       32'd0);
    reset = 1'b1;
    check("rel_ready_pre", 32'(req_ready), 32'd0);
    tick();
    check("rel_ready_1st", 32'(req_ready), 32'd1);

    // Write, zero wait states
    out_pready = 1'b1;
    send_req(32'h1000_0008, 1'b1, 32'h1234_5678, 4'hF);
    check("w0_psel_p1",    32'(out_psel),    32'd1);
    check("w0_pen_p1",     32'(out_penable), 32'd0);
    check("w0_paddr",      out_paddr,        32'h1000_0008);
    check("w0_pwrite",     32'(out_pwrite),  32'd1);
    check("w0_pwdata",     out_pwdata,       32'h1234_5678);
    check("w0_pstrb",      32'(out_pstrb),   32'hF);
    check("w0_pprot",      32'(out_pprot),   32'd0);
    check("w0_rdy_busy",   32'(req_ready),   32'd0);
    tick();
    check("w0_pen_p2",     32'(out_penable), 32'd1);
    check("w0_psel_p2",    32'(out_psel),    32'd1);
    check("w0_vld_p2",     32'(resp_valid),  32'd0);
    check("w0_paddr_p2",   out_paddr,        32'h1000_0008);
    tick();
    check("w0_vld_p3",     32'(resp_valid),  32'd1);
    check("w0_err",        32'(resp_err),    32'd0);
    check("w0_rdata",      resp_rdata,       32'd0);
    check("w0_psel_resp",  32'(out_psel),    32'd0);
    check("w0_pen_resp",   32'(out_penable), 32'd0);
    finish_resp();
    check("w0_idle_vld",   32'(resp_valid),  32'd0);
    check("w0_idle_rdy",   32'(req_ready),   32'd1);
    check("w0_idle_psel",  32'(out_psel),    32'd0);
    check("w0_idle_paddr", out_paddr,        32'h1000_0008);
    check("w0_idle_wdata", out_pwdata,       32'h1234_5678);

    // Read, three wait states
    out_pready = 1'b0;
    out_prdata = 32'h0BAD_0BAD;
    send_req(32'h1000_0004, 1'b0, 32'hFFFF_FFFF, 4'hF);
    check("r3_psel_p1",  32'(out_psel),   32'd1);
    check("r3_pstrb_p1", 32'(out_pstrb),  32'd0);
    check("r3_pwrite",   32'(out_pwrite), 32'd0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (c == 5) begin
        out_pready = 1'b1;
        out_prdata = 32'hDEAD_BEEF;
      end
      check($sformatf("r3_pen_p%0d", c),   32'(out_penable), 32'd1);
      check($sformatf("r3_pstrb_p%0d", c), 32'(out_pstrb),   32'd0);
      check($sformatf("r3_vld_p%0d", c),   32'(resp_valid),  32'd0);
    end
    tick();
    out_pready = 1'b0;
    out_prdata = 32'h0;
    check("r3_vld_p6",   32'(resp_valid), 32'd1);
    check("r3_rdata",    resp_rdata,      32'hDEAD_BEEF);
    check("r3_err",      32'(resp_err),   32'd0);
    check("r3_psel_p6",  32'(out_psel),   32'd0);
    finish_resp();

    // Write with slave error after one wait state
    out_prdata = 32'hCAFE_F00D;
    send_req(32'h2000_0010, 1'b1, 32'hA5A5_5A5A, 4'h3);
    check("we_pstrb", 32'(out_pstrb), 32'h3);
    tick();
    check("we_pen_p2", 32'(out_penable), 32'd1);
    tick();
    out_pready  = 1'b1;
    out_pslverr = 1'b1;
    check("we_vld_p3", 32'(resp_valid), 32'd0);
    tick();
    out_pready  = 1'b0;
    out_pslverr = 1'b0;
    check("we_vld_p4", 32'(resp_valid), 32'd1);
    check("we_err",    32'(resp_err),   32'd1);
    check("we_rdata",  resp_rdata,      32'd0);
    finish_resp();

    // Timeout: completer never responds
    out_pready = 1'b0;
    send_req(32'h3000_0000, 1'b0, 32'd0, 4'd0);
    acc = 0;
    for (int c = 0; c < 40 && resp_valid !== 1'b1; c++) begin
      tick();
      if (out_penable === 1'b1) acc++;
    end
    check("to_access_cycles", 32'(acc),          32'd16);
    check("to_vld",           32'(resp_valid),   32'd1);
    check("to_err",           32'(resp_err),     32'd1);
    check("to_rdata",         resp_rdata,        32'd0);
    check("to_psel",          32'(out_psel),     32'd0);
    check("to_pen",           32'(out_penable),  32'd0);
    finish_resp();

    // Response back-pressure, then back-to-back request
    out_pready = 1'b1;
    out_prdata = 32'h1357_9BDF;
    send_req(32'h1000_0020, 1'b0, 32'd0, 4'd0);
    tick();
    tick();
    out_prdata = 32'h0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_vld_%0d", c),   32'(resp_valid), 32'd1);
      check($sformatf("bp_rdata_%0d", c), resp_rdata,      32'h1357_9BDF);
      check($sformatf("bp_err_%0d", c),   32'(resp_err),   32'd0);
      check($sformatf("bp_rdy_%0d", c),   32'(req_ready),  32'd0);
      tick();
    end
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h1000_0024;
    req_write  = 1'b1;
    req_wdata  = 32'h0F0F_0F0F;
    req_wstrb  = 4'hC;
    tick();
    resp_ready = 1'b0;
    check("b2b_vld_idle", 32'(resp_valid), 32'd0);
    check("b2b_rdy_idle", 32'(req_ready),  32'd1);
    check("b2b_psel_idle", 32'(out_psel),  32'd0);
    tick();
    req_valid = 1'b0;
    check("b2b_psel",  32'(out_psel),    32'd1);
    check("b2b_pen",   32'(out_penable), 32'd0);
    check("b2b_paddr", out_paddr,        32'h1000_0024);
    check("b2b_pstrb", 32'(out_pstrb),   32'hC);
    tick();
    tick();
    check("b2b_vld",   32'(resp_valid), 32'd1);
    check("b2b_rdata", resp_rdata,      32'd0);
    check("b2b_err",   32'(resp_err),   32'd0);
    finish_resp();

    // Reset asserted during ACCESS
    out_pready = 1'b0;
    send_req(32'h4000_0000, 1'b0, 32'd0, 4'd0);
    tick();
    check("ra_pen_before", 32'(out_penable), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ra_psel",  32'(out_psel),    32'd0);
    check("ra_pen",   32'(out_penable), 32'd0);
    check("ra_vld",   32'(resp_valid),  32'd0);
    check("ra_rdy",   32'(req_ready),   32'd0);
    check("ra_paddr", out_paddr,        32'd0);
    out_pready = 1'b1;
    tick();
    check("ra_vld_hold", 32'(resp_valid), 32'd0);
    reset = 1'b1;
    check("ra_rdy_pre", 32'(req_ready), 32'd0);
    tick();
    check("ra_rdy_1st", 32'(req_ready),  32'd1);
    check("ra_vld_1st", 32'(resp_valid), 32'd0);
    check("ra_psel_1st", 32'(out_psel),  32'd0);
    tick();
    check("ra_vld_2nd", 32'(resp_valid), 32'd0);
    out_pready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
